// File: rtl/video_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : video_pkg                                                  |
// | Shared widths and pixel layout for the BK0010/11 video path.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package video_pkg;

    localparam int PIX_W    = 4;
    localparam int HCNT_W   = 10;
    localparam int DEF_LINE = 768;

    typedef struct packed {
        logic [1:0] r;
        logic       g;
        logic       b;
        logic       hbl;
    } pixel_t;

endpackage
`default_nettype wire

// File: rtl/scandoubler_linebuf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : scandoubler_linebuf                                        |
// | Simple dual-port line RAM, one write port, one registered read port. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module scandoubler_linebuf #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 5
) (
    input  logic              clk_sys,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk_sys) begin
        if (we) r_mem[waddr] <= wdata;
        if (re) r_rdata <= r_mem[raddr];
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/video_scandoubler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : video_scandoubler                                          |
// | Doubles 15.625 kHz lines to 31.25 kHz via a ping-pong line buffer.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module video_scandoubler #(
    parameter int HCNT_W   = video_pkg::HCNT_W,
    parameter int PIX_W    = video_pkg::PIX_W,
    parameter int DEF_LINE = video_pkg::DEF_LINE
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       ce_in,
    input  logic       ce_out,
    input  logic       bypass,
    input  logic [1:0] r_in,
    input  logic       g_in,
    input  logic       b_in,
    input  logic       hs_in,
    input  logic       vs_in,
    input  logic       hbl_in,
    input  logic       vbl_in,
    output logic [1:0] r_out,
    output logic       g_out,
    output logic       b_out,
    output logic       hs_out,
    output logic       vs_out,
    output logic       hbl_out,
    output logic       vbl_out
);

    import video_pkg::*;

    localparam int                c_data_w  = PIX_W + 1;
    localparam logic [HCNT_W-1:0] c_hc_max  = '1;
    localparam logic [HCNT_W:0]   c_def_len = (HCNT_W+1)'(DEF_LINE);

    logic              r_hs_in_d;
    logic [HCNT_W-1:0] r_hc_in;
    logic [HCNT_W-1:0] r_hc_out;
    logic [HCNT_W-1:0] r_hc_out_d;
    logic [HCNT_W-1:0] r_hs_w;
    logic [HCNT_W-1:0] r_hs_len;
    logic [HCNT_W:0]   r_line_len;
    logic              r_wbuf;
    logic [1:0]        r_line_flags;
    logic [1:0]        r_disp_flags;
    logic [1:0]        r_flags_d;
    logic [1:0]        r_red;
    logic              r_grn;
    logic              r_blu;
    logic              r_hs;
    logic              r_vs;
    logic              r_hbl;
    logic              r_vbl;

    pixel_t            w_wpix;
    pixel_t            w_rpix;
    logic              w_rise;
    logic              w_we;
    logic              w_wrap;

    assign w_rise = ce_in & hs_in & ~r_hs_in_d;
    assign w_we   = ce_in & (r_hc_in != c_hc_max);
    assign w_wpix = {r_in, g_in, b_in, hbl_in};
    assign w_wrap = ({1'b0, r_hc_out} == (r_line_len - (HCNT_W+1)'(1)));

    // Input time base: line measurement, write pointer and hsync width.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_hs_in_d    <= 1'b0;
            r_hc_in      <= '0;
            r_line_len   <= c_def_len;
            r_wbuf       <= 1'b0;
            r_hs_w       <= '0;
            r_hs_len     <= '0;
            r_line_flags <= '0;
            r_disp_flags <= '0;
        end else if (ce_in) begin
            r_hs_in_d <= hs_in;
            if (w_rise) begin
                r_line_len   <= {1'b0, r_hc_in} + (HCNT_W+1)'(1);
                r_hc_in      <= '0;
                r_wbuf       <= ~r_wbuf;
                r_disp_flags <= r_line_flags;
                r_line_flags <= {vs_in, vbl_in};
                r_hs_w       <= HCNT_W'(1);
            end else begin
                if (r_hc_in != c_hc_max) r_hc_in <= r_hc_in + HCNT_W'(1);
                if (hs_in && (r_hs_w != c_hc_max)) r_hs_w <= r_hs_w + HCNT_W'(1);
            end
            if (!hs_in && r_hs_in_d) r_hs_len <= r_hs_w;
        end
    end

    // Output time base, phase-locked to the input hsync rise.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_hc_out   <= '0;
            r_hc_out_d <= '0;
            r_flags_d  <= '0;
        end else if (ce_out) begin
            if (w_rise || w_wrap) r_hc_out <= '0;
            else                  r_hc_out <= r_hc_out + HCNT_W'(1);
            r_hc_out_d <= r_hc_out;
            r_flags_d  <= r_disp_flags;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_red <= '0;
            r_grn <= 1'b0;
            r_blu <= 1'b0;
            r_hs  <= 1'b0;
            r_vs  <= 1'b0;
            r_hbl <= 1'b0;
            r_vbl <= 1'b0;
        end else if (bypass) begin
            if (ce_in) begin
                r_red <= r_in;
                r_grn <= g_in;
                r_blu <= b_in;
                r_hs  <= hs_in;
                r_vs  <= vs_in;
                r_hbl <= hbl_in;
                r_vbl <= vbl_in;
            end
        end else if (ce_out) begin
            r_red <= w_rpix.r;
            r_grn <= w_rpix.g;
            r_blu <= w_rpix.b;
            r_hbl <= w_rpix.hbl;
            r_hs  <= (r_hc_out_d < r_hs_len);
            r_vs  <= r_flags_d[1];
            r_vbl <= r_flags_d[0];
        end
    end

    scandoubler_linebuf #(
        .ADDR_W (HCNT_W + 1),
        .DATA_W (c_data_w)
    ) u_linebuf (
        .clk_sys (clk_sys),
        .we      (w_we),
        .waddr   ({r_wbuf, r_hc_in}),
        .wdata   (w_wpix),
        .re      (ce_out),
        .raddr   ({~r_wbuf, r_hc_out}),
        .rdata   (w_rpix)
    );

    assign r_out   = r_red;
    assign g_out   = r_grn;
    assign b_out   = r_blu;
    assign hs_out  = r_hs;
    assign vs_out  = r_vs;
    assign hbl_out = r_hbl;
    assign vbl_out = r_vbl;

endmodule
`default_nettype wire

// File: tb/tb_video_scandoubler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_video_scandoubler                                       |
// | Random-stimulus bench with a line-level reference model.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_video_scandoubler;

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic       ce_in   = 1'b0;
    logic       ce_out  = 1'b0;
    logic       bypass  = 1'b0;
    logic [1:0] r_in    = '0;
    logic       g_in    = 1'b0;
    logic       b_in    = 1'b0;
    logic       hs_in   = 1'b0;
    logic       vs_in   = 1'b0;
    logic       hbl_in  = 1'b0;
    logic       vbl_in  = 1'b0;
    logic [1:0] r_out;
    logic       g_out, b_out, hs_out, vs_out, hbl_out, vbl_out;

    int n_checks = 0;
    int n_errors = 0;
    int hs_cnt   = 0;
    int vs_cnt   = 0;

    // Reference model state: RAM image with validity, write/read positions.
    logic [4:0] m_ram [0:2047];
    bit         m_val [0:2047];
    int         m_pos, m_opos, m_len, m_hsw, m_hslen;
    bit         m_buf, m_prev_hs;
    bit [1:0]   m_lflags, m_dflags;
    int         s1_opos;
    bit [1:0]   s1_flags;
    logic [4:0] s1_pix;
    bit         s1_val;
    logic [4:0] e_pix;
    bit         e_val, e_hs, e_vs, e_vbl;

    video_scandoubler dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .ce_in   (ce_in),
        .ce_out  (ce_out),
        .bypass  (bypass),
        .r_in    (r_in),
        .g_in    (g_in),
        .b_in    (b_in),
        .hs_in   (hs_in),
        .vs_in   (vs_in),
        .hbl_in  (hbl_in),
        .vbl_in  (vbl_in),
        .r_out   (r_out),
        .g_out   (g_out),
        .b_out   (b_out),
        .hs_out  (hs_out),
        .vs_out  (vs_out),
        .hbl_out (hbl_out),
        .vbl_out (vbl_out)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            if (n_errors <= 20)
                $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_opos = 0; m_len = 768; m_hsw = 0; m_hslen = 0;
        m_buf = 1'b0; m_prev_hs = 1'b0; m_lflags = '0; m_dflags = '0;
        s1_opos = 0; s1_flags = '0; s1_pix = '0; s1_val = 1'b0;
        e_pix = '0; e_val = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_vbl = 1'b0;
    endtask

    // Displayed output is two output steps behind the read position.
    task automatic model_out(input bit rise);
        int a;
        e_pix = s1_pix;
        e_val = s1_val;
        e_hs  = (s1_opos < m_hslen);
        e_vs  = s1_flags[1];
        e_vbl = s1_flags[0];
        a = (m_buf ? 0 : 1024) + m_opos;
        s1_pix   = m_ram[a];
        s1_val   = m_val[a];
        s1_opos  = m_opos;
        s1_flags = m_dflags;
        if (rise || (m_opos == m_len - 1)) m_opos = 0;
        else                               m_opos = (m_opos + 1) % 1024;
    endtask

    task automatic model_in(input bit rise);
        if (m_pos < 1023) begin
            m_ram[(m_buf ? 1024 : 0) + m_pos] = {r_in, g_in, b_in, hbl_in};
            m_val[(m_buf ? 1024 : 0) + m_pos] = 1'b1;
        end
        if (rise) begin
            m_len    = m_pos + 1;
            m_pos    = 0;
            m_buf    = !m_buf;
            m_dflags = m_lflags;
            m_lflags = {vs_in, vbl_in};
            m_hsw    = 1;
        end else begin
            if (m_pos < 1023) m_pos++;
            if (hs_in && m_hsw < 1023) m_hsw++;
        end
        if (!hs_in && m_prev_hs) m_hslen = m_hsw;
        m_prev_hs = hs_in;
    endtask

    task automatic clk_cycle(input bit ci, input bit co);
        bit rise;
        ce_in  = ci;
        ce_out = co;
        rise = ci && hs_in && !m_prev_hs;
        if (co) model_out(rise);
        if (ci) model_in(rise);
        @(posedge clk_sys);
        #1;
        if (bypass) begin
            if (ci)
                check_val("bypass", {r_out, g_out, b_out, hs_out, vs_out, hbl_out, vbl_out},
                          {r_in, g_in, b_in, hs_in, vs_in, hbl_in, vbl_in});
        end else if (co) begin
            check_val("sync", {hs_out, vs_out, vbl_out}, {e_hs, e_vs, e_vbl});
            if (e_val) check_val("pix", {r_out, g_out, b_out, hbl_out}, e_pix);
            hs_cnt += int'(hs_out);
            vs_cnt += int'(vs_out);
        end
        @(negedge clk_sys);
    endtask

    task automatic pix_tick(input logic [4:0] px, input bit hs, input bit vs, input bit vbl);
        {r_in, g_in, b_in, hbl_in} = px;
        hs_in = hs; vs_in = vs; vbl_in = vbl;
        clk_cycle(1'b1, 1'b1);
        clk_cycle(1'b0, 1'b0);
        clk_cycle(1'b0, 1'b1);
        clk_cycle(1'b0, 1'b0);
    endtask

    // mode 0: random pixels, 1: fixed pixel, 2: ramp 0..15 with random hbl
    task automatic send_line(input int len, input int hsw, input bit vs, input bit vbl,
                             input int mode, input logic [4:0] fixed);
        logic [4:0] px;
        for (int t = 0; t < len; t++) begin
            case (mode)
                0:       px = 5'($urandom);
                1:       px = fixed;
                default: px = {4'(t % 16), 1'($urandom)};
            endcase
            pix_tick(px, t < hsw, vs, vbl);
        end
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        check_val("rst_async", {r_out, g_out, b_out, hs_out, vs_out, hbl_out, vbl_out}, 0);
        model_reset();
        ce_in = 1'b0; ce_out = 1'b0;
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk_sys);
        check_val("rst_state", {r_out, g_out, b_out, hs_out, vs_out, hbl_out, vbl_out}, 0);
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;

        // Steady 768-pixel lines; hsync width 56
        repeat (3) send_line(768, 56, 1'b0, 1'b0, 0, '0);
        hs_cnt = 0;
        send_line(768, 56, 1'b0, 1'b0, 0, '0);
        check_val("hs_width", hs_cnt, 112);

        // Buffer swap with solid colours 4'h5 then 4'hA
        repeat (2) send_line(768, 56, 1'b0, 1'b0, 1, {4'h5, 1'b0});
        repeat (2) send_line(768, 56, 1'b0, 1'b0, 1, {4'hA, 1'b0});
        send_line(768, 56, 1'b0, 1'b0, 0, '0);

        // Vertical sync over four short input lines
        vs_cnt = 0;
        for (int i = 0; i < 10; i++)
            send_line(200, 20, (i >= 3 && i <= 6), (i >= 2 && i <= 7), 0, '0);
        repeat (2) send_line(768, 56, 1'b0, 1'b0, 0, '0);
        check_val("vs_lines", vs_cnt, 1600);

        // Missing hsync: write pointer saturates, output keeps wrapping
        send_line(1200, 56, 1'b0, 1'b0, 0, '0);
        repeat (2) send_line(768, 56, 1'b0, 1'b0, 0, '0);

        // Bypass with a pixel ramp
        bypass = 1'b1;
        repeat (4) send_line(64, 8, 1'b0, 1'b0, 2, '0);
        bypass = 1'b0;
        repeat (3) send_line(100, 10, 1'b0, 1'b0, 0, '0);

        // Reset mid-line, then free-run without hsync before lines resume
        send_line(300, 56, 1'b0, 1'b0, 0, '0);
        do_reset();
        send_line(1000, 0, 1'b0, 1'b0, 0, '0);
        repeat (3) send_line(768, 56, 1'b0, 1'b0, 0, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/video_scandoubler.md
Name: video_scandoubler

Overview:
- Downstream stage of the BK0010/11 video generator. Doubles its 15.625 kHz / 768-pixel lines to 31.25 kHz for VGA-class monitors.
- Each input line is written into one half of a ping-pong line buffer at the 12 MHz pixel rate. The previous line is read out twice at 24 MHz.
- Sync and blank are regenerated on the output time base.
- Sits between the video generator and the board video DAC/OSD.

Parameters:
- HCNT_W, 10, width of line position counters; max line length 2^HCNT_W.
- PIX_W, 4, pixel width, packed {R[1],R[0],G,B}.
- DEF_LINE, 768, line length used after reset until first measurement.

Ports:
- clk_sys  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- ce_in  in  1  input pixel enable, 12 MHz (ce_12mn rate).
- ce_out  in  1  output pixel enable, 24 MHz; every ce_in cycle is also a ce_out cycle.
- bypass  in  1  1 = pass input through registered, no doubling.
- r_in  in  2  input red.
- g_in  in  1  input green.
- b_in  in  1  input blue.
- hs_in  in  1  input HSync, active high.
- vs_in  in  1  input VSync, active high.
- hbl_in  in  1  input HBlank.
- vbl_in  in  1  input VBlank.
- r_out  out  2  output red.
- g_out  out  1  output green.
- b_out  out  1  output blue.
- hs_out  out  1  output HSync.
- vs_out  out  1  output VSync.
- hbl_out  out  1  output HBlank.
- vbl_out  out  1  output VBlank.

Behaviour:
- Reset (reset_n=0, async): all outputs 0; hc_in=hc_out=0; wbuf=0; line_len=DEF_LINE; hs_w=0.
- Input side, per ce_in:
  - hs_in rise is detected against a registered copy of hs_in.
  - On the rise: line_len<=hc_in+1, hc_in<=0, wbuf<=~wbuf, latch {vs_in,vbl_in} into line_flags.
  - Otherwise hc_in increments and saturates at 2^HCNT_W-1.
  - hs_w counts ce_in while hs_in=1, saturating. It is latched into hs_len on the hs_in fall and cleared at the next rise.
  - Write {r_in,g_in,b_in,hbl_in} to buffer half wbuf, address hc_in, every ce_in until saturation. At saturation, writing stops; there is no address wrap.
- Output side, per ce_out:
  - hc_out<=0 on the ce_out coinciding with an input hs rise (phase lock).
  - Otherwise hc_out<=0 when hc_out==line_len-1; this is the second line start. Else hc_out increments.
  - Without new input hs, wrapping repeats indefinitely.
- Read address {~wbuf, hc_out}. The RAM has 1-cycle read latency.
- Output register stage (updated on ce_out; holds otherwise):
  - Pixel and hbl_out come from RAM data.
  - hs_out=(hc_out_d < hs_len), where hc_out_d is hc_out delayed to match RAM latency.
  - vs_out/vbl_out come from line_flags of the line being displayed.
- Total latency: one input line plus 2 ce_out. Pixel k of line N appears at output lines 2N+2 and 2N+3, position k.
- Simultaneous hs rise and hc_out wrap: the hs rise wins, and hc_out goes to 0 once.
- line_len smaller than the previous value takes effect immediately on the next hs rise.
- bypass=1: outputs are inputs registered on ce_in; the buffer still runs. Switching bypass mid-frame may produce one corrupt line; this is accepted.
- Async reset mid-line: immediate clear. The first two output lines after release show stale RAM content with correct syncs.

Decomposition:
- Package video_pkg: PIX_W, HCNT_W, DEF_LINE, and a packed pixel struct {r[1:0],g,b,hbl}.
- Sub-module scandoubler_linebuf:
  - Simple dual-port RAM, 2^(HCNT_W+1) x 5.
  - One write port (we, waddr, wdata) and one registered read port; no reset.

Test Plan:
- Reset: assert reset_n=0 mid-stream -> all outputs 0 immediately; after release line_len=768, hc_out restarts at 0.
- Steady lines: 768-tick lines, hs_in high 56 ticks -> two output lines of 768 ce_out each per input line; hs_out high for 56 ce_out at each output line start.
- Buffer swap: line N all pixels 4'h5, line N+1 all 4'hA -> output lines 2N+2 and 2N+3 show 5, then 2N+4 and 2N+5 show A; no mixing.
- VSync/VBlank: vs_in high for input lines 276..279 -> vs_out high for exactly 8 consecutive output lines, delayed one input line.
- Missing hsync: hold hs_in low 1100 ce_in -> hc_in saturates at 1023, no overwrite at address 0; output keeps wrapping at 768.
- Bypass: bypass=1, pixel ramp 0..15 -> outputs equal inputs one ce_in later, hs_out==hs_in delayed 1.
